// File: rtl/pll_seq_pkg.sv
// Shared types for the rPLL lock sequencer: FSM states, select bundle and a
// saturating counter helper.
package pll_seq_pkg;

    localparam int SEL_W = 6;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] idsel;
        logic [SEL_W-1:0] fbdsel;
        logic [SEL_W-1:0] odsel;
    } sel_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Divider reconfiguration request channel (valid/ready with three select fields).
interface pll_lock_sequencer_if;
    import pll_seq_pkg::*;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [SEL_W-1:0] cfg_idsel;
    logic [SEL_W-1:0] cfg_fbdsel;
    logic [SEL_W-1:0] cfg_odsel;

    modport master (
        output cfg_valid,
        output cfg_idsel,
        output cfg_fbdsel,
        output cfg_odsel,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_idsel,
        input  cfg_fbdsel,
        input  cfg_odsel,
        output cfg_ready
    );

endinterface

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous levels into clk.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences rPLL reset and divider selects, supervises lock, and holds the
// downstream reset until lock has been stable long enough.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int               RST_CYCLES   = 16,
    parameter int               LOCK_STABLE  = 1024,
    parameter int               LOCK_TIMEOUT = 65536,
    parameter int               MAX_RETRIES  = 3,
    parameter logic [SEL_W-1:0] DEF_IDSEL    = 6'd0,
    parameter logic [SEL_W-1:0] DEF_FBDSEL   = 6'd0,
    parameter logic [SEL_W-1:0] DEF_ODSEL    = 6'd0,
    parameter int               CNT_W        = 17
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pll_lock_sequencer_if.slave  cfg,
    input  logic                 pll_lock,
    output logic                 pll_reset,
    output logic [SEL_W-1:0]     pll_idsel,
    output logic [SEL_W-1:0]     pll_fbdsel,
    output logic [SEL_W-1:0]     pll_odsel,
    output logic                 sys_reset_n,
    output logic                 locked,
    output logic                 error,
    output logic [1:0]           retries,
    output logic [7:0]           lost_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]       MAX_R        = 2'(MAX_RETRIES);
    localparam sel_t             DEF_SEL      = {DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL};

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    sel_t             sel_q;
    sel_t             sel_n;
    logic [1:0]       retries_n;
    logic [7:0]       lost_n;
    logic             ready_q;
    logic             lock_s;
    logic             accept;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_lock),
        .q       (lock_s)
    );

    assign cfg.cfg_ready = ready_q;
    assign pll_idsel     = sel_q.idsel;
    assign pll_fbdsel    = sel_q.fbdsel;
    assign pll_odsel     = sel_q.odsel;

    // A handshake overrides whatever the lock supervision decided this cycle,
    // except that a coincident lock loss in RUN is still counted.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sel_n     = sel_q;
        retries_n = retries;
        lost_n    = lost_cnt;
        accept    = cfg.cfg_valid && ready_q;

        case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_n = '0;
                    if (retries < MAX_R) begin
                        retries_n = retries + 2'd1;
                        state_n   = RESET_PLL;
                    end else begin
                        state_n = FAIL;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    lost_n    = sat_inc8(lost_cnt);
                    retries_n = 2'd0;
                    state_n   = RESET_PLL;
                    cnt_n     = '0;
                end
            end
            FAIL: begin
                state_n = FAIL;
            end
            default: begin
                state_n = RESET_PLL;
                cnt_n   = '0;
            end
        endcase

        if (accept) begin
            sel_n     = {cfg.cfg_idsel, cfg.cfg_fbdsel, cfg.cfg_odsel};
            retries_n = 2'd0;
            state_n   = RESET_PLL;
            cnt_n     = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            sel_q       <= DEF_SEL;
            retries     <= 2'd0;
            lost_cnt    <= 8'd0;
            pll_reset   <= 1'b1;
            sys_reset_n <= 1'b0;
            locked      <= 1'b0;
            error       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sel_q       <= sel_n;
            retries     <= retries_n;
            lost_cnt    <= lost_n;
            pll_reset   <= (state_n == RESET_PLL) || (state_n == FAIL);
            sys_reset_n <= (state_n == RUN);
            locked      <= (state_n == RUN);
            error       <= (state_n == FAIL);
            ready_q     <= (state_n == RUN) || (state_n == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed sequences, a vector table
// and randomized traffic compared against a cycle-level behavioural model.
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 32;
    localparam int MAX_RETRIES  = 2;
    localparam logic [32:0] RESET_VEC = 33'h1_0000_0000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       sys_reset_n, locked, error;
    logic [1:0] retries;
    logic [7:0] lost_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_sequencer_if cfg_if ();

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRIES  (MAX_RETRIES),
        .DEF_IDSEL    (6'd0),
        .DEF_FBDSEL   (6'd0),
        .DEF_ODSEL    (6'd0),
        .CNT_W        (17)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg         (cfg_if),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .pll_idsel   (pll_idsel),
        .pll_fbdsel  (pll_fbdsel),
        .pll_odsel   (pll_odsel),
        .sys_reset_n (sys_reset_n),
        .locked      (locked),
        .error       (error),
        .retries     (retries),
        .lost_cnt    (lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] out_vec();
        return {pll_reset, sys_reset_n, locked, error, cfg_if.cfg_ready, retries, lost_cnt,
                pll_idsel, pll_fbdsel, pll_odsel};
    endfunction

    // Behavioural model: phase plus time-in-phase, lock seen through a 2-deep history.
    localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FAIL = 4;
    int       m_phase, m_time, m_retries, m_lost;
    logic [5:0] m_id, m_fb, m_od;
    bit       lock_hist[$];
    bit       model_valid = 0;

    always @(posedge clk) begin
        bit ls;
        bit acc;
        int nxt;
        if (!reset_n) begin
            m_phase = M_RST; m_time = 0; m_retries = 0; m_lost = 0;
            m_id = 6'd0; m_fb = 6'd0; m_od = 6'd0;
            lock_hist = '{1'b0, 1'b0};
            model_valid = 1;
        end else if (model_valid) begin
            ls  = lock_hist[0];
            acc = cfg_if.cfg_valid && (m_phase == M_RUN || m_phase == M_FAIL);
            nxt = -1;
            m_time++;
            if (acc) begin
                if (m_phase == M_RUN && !ls) m_lost = (m_lost < 255) ? m_lost + 1 : 255;
                m_id = cfg_if.cfg_idsel; m_fb = cfg_if.cfg_fbdsel; m_od = cfg_if.cfg_odsel;
                m_retries = 0;
                nxt = M_RST;
            end else begin
                case (m_phase)
                    M_RST:  if (m_time == RST_CYCLES) nxt = M_WAIT;
                    M_WAIT: if (ls) nxt = M_STAB;
                            else if (m_time == LOCK_TIMEOUT) begin
                                if (m_retries < MAX_RETRIES) begin m_retries++; nxt = M_RST; end
                                else nxt = M_FAIL;
                            end
                    M_STAB: if (!ls) nxt = M_WAIT; else if (m_time == LOCK_STABLE) nxt = M_RUN;
                    M_RUN:  if (!ls) begin
                                m_lost = (m_lost < 255) ? m_lost + 1 : 255;
                                m_retries = 0;
                                nxt = M_RST;
                            end
                    default: ;
                endcase
            end
            if (nxt >= 0) begin m_phase = nxt; m_time = 0; end
            void'(lock_hist.pop_front());
            lock_hist.push_back(pll_lock);
        end
    end

    function automatic logic [32:0] model_vec();
        logic rst_o, run_o, fail_o;
        rst_o  = (m_phase == M_RST) || (m_phase == M_FAIL);
        run_o  = (m_phase == M_RUN);
        fail_o = (m_phase == M_FAIL);
        return {rst_o, run_o, run_o, fail_o, run_o | fail_o, 2'(m_retries), 8'(m_lost),
                m_id, m_fb, m_od};
    endfunction

    always @(negedge clk) begin
        if (model_valid) check_output("model", 64'(out_vec()), 64'(model_vec()));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
        cfg_if.cfg_idsel  = id;
        cfg_if.cfg_fbdsel = fb;
        cfg_if.cfg_odsel  = od;
        cfg_if.cfg_valid  = 1'b1;
        step(1);
        cfg_if.cfg_valid  = 1'b0;
    endtask

    task automatic wait_run(input int budget, output int edges);
        edges = 0;
        while (!locked && edges < budget) begin
            step(1);
            edges++;
        end
        if (!locked) check_output("wait_run_timeout", 64'(locked), 64'd1);
    endtask

    task automatic bring_up();
        int e;
        reset_n = 1'b0;
        step(2);
        reset_n  = 1'b1;
        pll_lock = 1'b1;
        wait_run(200, e);
    endtask

    typedef struct {
        logic [5:0] id, fb, od;
        int         delay;
        logic [5:0] eid, efb, eod;
        int         eedges;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int e;
        int hold;
        // Relock edge after handshake H: STABLE at max(H+5, H+delay+2), RUN 8 edges later.
        vecs[0] = '{6'd5,  6'd9,  6'd32, 3,  6'd5,  6'd9,  6'd32, 13};
        vecs[1] = '{6'd63, 6'd0,  6'd1,  6,  6'd63, 6'd0,  6'd1,  16};
        vecs[2] = '{6'd17, 6'd40, 6'd2,  12, 6'd17, 6'd40, 6'd2,  22};
        vecs[3] = '{6'd0,  6'd0,  6'd0,  20, 6'd0,  6'd0,  6'd0,  30};

        reset_n = 1'b0; pll_lock = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_idsel = '0; cfg_if.cfg_fbdsel = '0; cfg_if.cfg_odsel = '0;
        step(3);
        check_output("reset_values", 64'(out_vec()), 64'(RESET_VEC));

        // Power-up: 4-cycle reset pulse, lock 10 cycles after release.
        reset_n = 1'b1;
        step(3);
        check_output("pwr_pll_reset_held", 64'(pll_reset), 64'd1);
        step(1);
        check_output("pwr_pll_reset_fall", 64'(pll_reset), 64'd0);
        step(6);
        pll_lock = 1'b1;
        step(1);
        e = 0;
        while (!sys_reset_n && e < 100) begin step(1); e++; end
        check_output("pwr_release_edges", 64'(e), 64'd10);
        check_output("pwr_run_outputs", 64'({locked, cfg_if.cfg_ready, pll_idsel, pll_fbdsel, pll_odsel}),
                     64'({1'b1, 1'b1, 18'd0}));

        // Table: reconfiguration in RUN with varied relock delays.
        for (int i = 0; i < 4; i++) begin
            wait_run(100, e);
            apply_stimulus(vecs[i].id, vecs[i].fb, vecs[i].od);
            pll_lock = 1'b0;
            check_output($sformatf("vec%0d_sel", i), 64'({pll_idsel, pll_fbdsel, pll_odsel}),
                         64'({vecs[i].eid, vecs[i].efb, vecs[i].eod}));
            check_output($sformatf("vec%0d_leave_run", i),
                         64'({sys_reset_n, locked, cfg_if.cfg_ready, pll_reset}), 64'(4'b0001));
            step(vecs[i].delay - 1);
            pll_lock = 1'b1;
            e = vecs[i].delay - 1;
            while (!sys_reset_n && e < 100) begin step(1); e++; end
            check_output($sformatf("vec%0d_relock_edges", i), 64'(e), 64'(vecs[i].eedges));
        end

        // One-cycle lock glitch in RUN.
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(1);
        check_output("glitch_run_still_locked", 64'(locked), 64'd1);
        step(1);
        check_output("glitch_run_drop", 64'({locked, pll_reset, retries, lost_cnt}),
                     64'({1'b0, 1'b1, 2'd0, 8'd1}));
        wait_run(100, e);

        // Handshake coinciding with synchronised lock loss.
        pll_lock = 1'b0;
        step(2);
        apply_stimulus(6'd7, 6'd8, 6'd9);
        check_output("simul_sel_lost", 64'({pll_idsel, pll_fbdsel, pll_odsel, lost_cnt, sys_reset_n}),
                     64'({6'd7, 6'd8, 6'd9, 8'd2, 1'b0}));
        pll_lock = 1'b1;
        wait_run(100, e);

        // Glitch during STABLE: back to WAIT_LOCK without a retry.
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        pll_lock = 1'b1;
        step(5);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(2);
        check_output("stable_glitch_wait", 64'({retries, pll_reset, locked}), 64'({2'd0, 1'b0, 1'b0}));
        e = 0;
        while (!locked && e < 100) begin step(1); e++; end
        check_output("stable_glitch_relock_edges", 64'(e), 64'd9);

        // Lock never arrives: three pulses then FAIL.
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        pll_lock = 1'b0;
        step(35);
        check_output("to_before_first", 64'({pll_reset, retries}), 64'({1'b0, 2'd0}));
        step(1);
        check_output("to_first_retry", 64'({pll_reset, retries}), 64'({1'b1, 2'd1}));
        step(71);
        check_output("to_before_fail", 64'({error, pll_reset, retries}), 64'({1'b0, 1'b0, 2'd2}));
        step(1);
        check_output("to_fail", 64'({error, pll_reset, cfg_if.cfg_ready, sys_reset_n, retries}),
                     64'({1'b1, 1'b1, 1'b1, 1'b0, 2'd2}));
        step(5);
        check_output("to_fail_holds", 64'(error), 64'd1);
        apply_stimulus(6'd1, 6'd2, 6'd3);
        check_output("fail_restart", 64'({error, retries, cfg_if.cfg_ready, pll_reset, pll_idsel, pll_fbdsel, pll_odsel}),
                     64'({1'b0, 2'd0, 1'b0, 1'b1, 6'd1, 6'd2, 6'd3}));
        pll_lock = 1'b1;
        wait_run(100, e);

        // reset_n in STABLE after a reconfiguration.
        bring_up();
        apply_stimulus(6'd11, 6'd22, 6'd33);
        step(5);
        check_output("stable_after_cfg", 64'({locked, pll_reset, pll_idsel, pll_fbdsel, pll_odsel}),
                     64'({1'b0, 1'b0, 6'd11, 6'd22, 6'd33}));
        reset_n = 1'b0;
        step(1);
        check_output("midseq_reset", 64'(out_vec()), 64'(RESET_VEC));
        reset_n = 1'b1;

        // 300 lock losses saturate lost_cnt.
        bring_up();
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            step(1);
            pll_lock = 1'b1;
            step(2);
            wait_run(100, e);
            if (i == 99) check_output("lost_100", 64'(lost_cnt), 64'd100);
        end
        check_output("lost_saturated", 64'(lost_cnt), 64'd255);

        // Randomized traffic against the model.
        hold = 1;
        for (int c = 0; c < 3000; c++) begin
            hold--;
            if (hold == 0) begin
                pll_lock = ~pll_lock;
                hold = int'($urandom_range(60, 1));
            end
            cfg_if.cfg_valid  = ($urandom_range(15, 0) == 0);
            cfg_if.cfg_idsel  = 6'($urandom);
            cfg_if.cfg_fbdsel = 6'($urandom);
            cfg_if.cfg_odsel  = 6'($urandom);
            reset_n = ($urandom_range(700, 0) != 0);
            step(1);
        end
        cfg_if.cfg_valid = 1'b0;
        reset_n = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
